// File: rtl/logic_pkg.sv
// Shared helpers for the logic clock-domain-crossing FIFO family.
package logic_pkg;

    localparam int unsigned LOGIC_POINTER_GUARD_BITS = 32'd1;

    // Number of entries addressed by a memory of the given address width.
    function automatic int unsigned logic_fifo_depth(input int unsigned address_width);
        logic_fifo_depth = 32'd1 << address_width;
    endfunction

endpackage

// File: rtl/write.sv
// Write-side controller of the generic dual-clock FIFO: handshake, write pointer, level and full.
// Optional almost_full register enabled by LOGIC_CLOCK_DOMAIN_CROSSING_WRITE_ALMOST_FULL_EN.
module write
    import logic_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH         = 32'd1,
    parameter int unsigned ALMOST_FULL_THRESHOLD = logic_fifo_depth(ADDRESS_WIDTH) - 32'd1
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     rx_tvalid,
    output logic                     rx_tready,
    input  logic [ADDRESS_WIDTH:0]   read_pointer_synced,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [ADDRESS_WIDTH:0]   write_pointer,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     full,
    output logic                     almost_full
);

    localparam int unsigned POINTER_WIDTH = ADDRESS_WIDTH + LOGIC_POINTER_GUARD_BITS;
    localparam int unsigned DEPTH         = logic_fifo_depth(ADDRESS_WIDTH);
    localparam logic [POINTER_WIDTH-1:0] DEPTH_LEVEL = POINTER_WIDTH'(DEPTH);

    logic                     accept_s;
    logic [POINTER_WIDTH-1:0] write_pointer_next_s;
    logic [POINTER_WIDTH-1:0] level_next_s;
    logic                     full_next_s;

    logic [POINTER_WIDTH-1:0] write_pointer_r;
    logic [POINTER_WIDTH-1:0] level_r;
    logic                     full_r;
    logic                     rx_tready_r;

    // Next pointer and level; the subtraction wraps naturally, so a lagging read pointer only overstates the level.
    always_comb begin
        accept_s             = rx_tvalid & rx_tready_r;
        write_pointer_next_s = write_pointer_r + {{(POINTER_WIDTH-1){1'b0}}, accept_s};
        level_next_s         = write_pointer_next_s - read_pointer_synced;
        full_next_s          = (level_next_s == DEPTH_LEVEL);
    end

    // Pointer, level and flag pipeline; ready stays low through reset and rises on the first released edge.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            write_pointer_r <= {POINTER_WIDTH{1'b0}};
            level_r         <= {POINTER_WIDTH{1'b0}};
            full_r          <= 1'b0;
            rx_tready_r     <= 1'b0;
        end else begin
            write_pointer_r <= write_pointer_next_s;
            level_r         <= level_next_s;
            full_r          <= full_next_s;
            rx_tready_r     <= !full_next_s;
        end
    end

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_WRITE_ALMOST_FULL_EN
    localparam logic [POINTER_WIDTH-1:0] ALMOST_FULL_LEVEL = POINTER_WIDTH'(ALMOST_FULL_THRESHOLD);

    logic almost_full_r;

    // Almost-full flag tracks the same next level as full, so both move on the same edge.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            almost_full_r <= 1'b0;
        end else begin
            almost_full_r <= (level_next_s >= ALMOST_FULL_LEVEL);
        end
    end

    assign almost_full = almost_full_r;
`else
    assign almost_full = 1'b0;
`endif

    assign rx_tready     = rx_tready_r;
    assign write_enable  = accept_s;
    assign write_address = write_pointer_r[ADDRESS_WIDTH-1:0];
    assign write_pointer = write_pointer_r;
    assign level         = level_r;
    assign full          = full_r;

endmodule

// File: tb/tb_write.sv
// Directed self-checking bench for the FIFO write controller (ADDRESS_WIDTH=2, DEPTH=4).
module tb_write;

    localparam int unsigned AW = 2;

    logic          aclk;
    logic          areset_n;
    logic          rx_tvalid;
    logic          rx_tready;
    logic [AW:0]   read_pointer_synced;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [AW:0]   write_pointer;
    logic [AW:0]   level;
    logic          full;
    logic          almost_full;

    write #(
        .ADDRESS_WIDTH         (AW),
        .ALMOST_FULL_THRESHOLD (3)
    ) dut (
        .aclk                (aclk),
        .areset_n            (areset_n),
        .rx_tvalid           (rx_tvalid),
        .rx_tready           (rx_tready),
        .read_pointer_synced (read_pointer_synced),
        .write_enable        (write_enable),
        .write_address       (write_address),
        .write_pointer       (write_pointer),
        .level               (level),
        .full                (full),
        .almost_full         (almost_full)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW:0]   m_wp;
    logic [AW:0]   m_level;
    logic          m_full;
    logic          m_ready;
    logic          m_af;
    logic [AW-1:0] addr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".write_pointer"}, 32'(write_pointer), 32'(m_wp));
        check({tag, ".level"},         32'(level),         32'(m_level));
        check({tag, ".full"},          32'(full),          32'(m_full));
        check({tag, ".rx_tready"},     32'(rx_tready),     32'(m_ready));
        check({tag, ".almost_full"},   32'(almost_full),   32'(m_af));
    endtask

    // One clock: drive inputs, check the combinational strobe, advance the model, check registers after the edge.
    task automatic cycle(input string tag, input logic v, input logic [AW:0] rp);
        logic          acc;
        logic [AW-1:0] exp_addr;
        rx_tvalid           = v;
        read_pointer_synced = rp;
        acc = v & m_ready;
        if (acc) addr_q.push_back(m_wp[AW-1:0]);
        #1;
        check({tag, ".write_enable"}, 32'(write_enable), 32'(acc));
        if (write_enable === 1'b1) begin
            if (addr_q.size() == 0) begin
                check({tag, ".unexpected_write"}, 32'd1, 32'd0);
            end else begin
                exp_addr = addr_q.pop_front();
                check({tag, ".write_address"}, 32'(write_address), 32'(exp_addr));
            end
        end
        m_wp    = m_wp + {2'b00, acc};
        m_level = m_wp - rp;
        m_full  = (m_level == 3'd4);
        m_ready = !m_full;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_WRITE_ALMOST_FULL_EN
        m_af    = (m_level >= 3'd3);
`else
        m_af    = 1'b0;
`endif
        @(negedge aclk);
        check_state(tag);
    endtask

    task automatic do_reset(input logic [AW:0] rp_during);
        areset_n            = 1'b0;
        rx_tvalid           = 1'b1;
        read_pointer_synced = rp_during;
        m_wp = '0; m_level = '0; m_full = 1'b0; m_ready = 1'b0; m_af = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge aclk);
        check_state("reset");
        #1;
        check("reset.write_enable", 32'(write_enable), 32'd0);
        rx_tvalid           = 1'b0;
        read_pointer_synced = 3'd0;
        areset_n            = 1'b1;
    endtask

    initial begin
        areset_n            = 1'b0;
        rx_tvalid           = 1'b0;
        read_pointer_synced = 3'd0;
        @(negedge aclk);

        // Reset with a nonzero read pointer present, then release
        do_reset(3'd3);
        cycle("release_reset", 1'b0, 3'd0);

        // Fill: four accepts, fifth beat refused
        for (int i = 0; i < 5; i++) cycle("fill", 1'b1, 3'd0);
        check("fill.queue_empty", 32'(addr_q.size()), 32'd0);

        // Release from full, then one more accept at address 0
        cycle("release", 1'b0, 3'd1);
        cycle("release_accept", 1'b1, 3'd1);
        cycle("refull_hold", 1'b1, 3'd1);

        // Simultaneous accept and read advance at level 3
        cycle("to_level3", 1'b0, 3'd2);
        cycle("simultaneous", 1'b1, 3'd3);

        // Drain to level 1, then stream 20 beats with the read pointer trailing by one
        cycle("drain", 1'b0, 3'd5);
        for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, m_wp);
        cycle("wrap_idle", 1'b0, m_wp);

        // Mid-operation reset, then threshold crossing for almost_full
        do_reset(3'd2);
        cycle("af_release", 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) cycle("af_fill", 1'b1, 3'd0);
        cycle("af_drop", 1'b0, 3'd1);
        cycle("af_rise_again", 1'b1, 3'd1);

        check("final.queue_empty", 32'(addr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
